// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DIGITS_DEF = 8;
    localparam int BIN_W_DEF  = 27;

    localparam logic [3:0] BCD_SAT = 4'h9;

    // Largest value representable in the given number of decimal digits.
    function automatic logic [63:0] max_dec(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: one BCD nibble, purely combinational.
module bcd_add3 (
    input  logic [3:0] nibble,
    output logic [3:0] adjusted
);

    assign adjusted = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary to packed BCD converter with saturation/overflow.
// Optional macro BCD_AUTO_EN: also start a conversion whenever bin differs from the last value converted.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(max_dec(DIGITS));

    state_t              state;
    logic [WORK_W-1:0]   work;
    logic [WORK_W-1:0]   work_adj;
    logic [CNT_W-1:0]    cnt;
    logic                ovf_pending;
    logic                trigger;

    // Binary field passes through; every BCD nibble is corrected in parallel before the shift.
    assign work_adj[BIN_W-1:0] = work[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .nibble   (work[BIN_W + 4*g +: 4]),
            .adjusted (work_adj[BIN_W + 4*g +: 4])
        );
    end

`ifdef BCD_AUTO_EN
    logic [BIN_W-1:0] last_bin;

    assign trigger = start || (bin != last_bin);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_bin <= '0;
        end else if (state == IDLE && trigger) begin
            last_bin <= bin;
        end
    end
`else
    assign trigger = start;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            work        <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bcd         <= '0;
            ovf         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        work        <= {{BCD_W{1'b0}}, bin};
                        cnt         <= CNT_W'(BIN_W);
                        ovf_pending <= (bin > MAX_BIN);
                        busy        <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Carry out of the top nibble is dropped; overflow was decided at capture.
                    work <= {work_adj[WORK_W-2:0], 1'b0};
                    cnt  <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd   <= ovf_pending ? {DIGITS{BCD_SAT}} : work[WORK_W-1 -: BCD_W];
                    ovf   <= ovf_pending;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: decimal reference model, randomized and boundary values.
module tb_bin2bcd_seq;

    localparam int LAT = 28;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [26:0] bin   = '0;
    logic        busy;
    logic        done;
    logic [31:0] bcd;
    logic        ovf;

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc      = 0;
    int          n_vec    = 0;
    int          n_err    = 0;
    logic [31:0] last_exp = '0;

    bin2bcd_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Decimal digits by repeated division; saturate above eight digits.
    function automatic logic [31:0] ref_bcd(input int unsigned v);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        if (v > 99999999) return 32'h99999999;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [26:0] v);
        exp_t e;
        e.bcd = ref_bcd(32'(v));
        e.ovf = (32'(v) > 99999999);
        e.cyc = cyc + LAT;
        sb.push_back(e);
        last_exp = e.bcd;
    endtask

    // Called away from the rising edge; drives start for exactly one edge.
    task automatic do_start(input logic [26:0] v, input bit expect_it);
        start = 1'b1;
        bin   = v;
        @(posedge clk);
        #1;
        if (expect_it) push_exp(v);
        start = 1'b0;
    endtask

    task automatic wait_done(output int nbusy);
        nbusy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) return;
            if (busy) nbusy++;
        end
        n_vec++;
        n_err++;
        $display("FAIL done_timeout: got no done within 100 cycles, expected done");
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done with bcd=%h, expected no done", bcd);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("bcd", 64'(bcd), 64'(e.bcd));
                check("ovf", 64'(ovf), 64'(e.ovf));
                check("latency_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int unsigned v;
        logic [26:0] bnd [7];
        bnd = '{27'd0, 27'd99999999, 27'd100000000, 27'd134217727, 27'd1, 27'd9, 27'd10};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_after_reset", 64'({busy, done, ovf, bcd}), 64'd0);
        end

`ifdef BCD_AUTO_EN
        bin = 27'd909;
        @(posedge clk);
        #1;
        push_exp(27'd909);
        wait_done(nb);
        check("busy_cycles", 64'(nb), 64'(LAT));
        repeat (60) @(negedge clk);
        check("no_retrigger", 64'(sb.size()), 64'd0);
        bin = 27'd12;
        @(posedge clk);
        #1;
        push_exp(27'd12);
        wait_done(nb);
        start = 1'b1;
        @(posedge clk);
        #1;
        push_exp(27'd12);
        start = 1'b0;
        wait_done(nb);
        repeat (40) @(negedge clk);
`else
        do_start(27'd12345678, 1'b1);
        bin = 27'($urandom);
        wait_done(nb);
        check("busy_cycles", 64'(nb), 64'(LAT));

        foreach (bnd[i]) begin
            do_start(bnd[i], 1'b1);
            wait_done(nb);
        end

        do_start(27'd42, 1'b1);
        repeat (9) @(negedge clk);
        start = 1'b1;
        bin   = 27'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done(nb);
        do_start(27'd7, 1'b1);
        wait_done(nb);

        for (int i = 0; i < 24; i++) begin
            case (i % 3)
                0:       v = $urandom_range(0, 99999999);
                1:       v = $urandom_range(0, 134217727);
                default: v = $urandom_range(0, 9999);
            endcase
            do_start(27'(v), 1'b1);
            bin = 27'($urandom);
            wait_done(nb);
        end

        repeat (10) @(negedge clk);
        check("bcd_hold", 64'(bcd), 64'(last_exp));

        do_start(27'd555, 1'b0);
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_abort", 64'({busy, done, ovf, bcd}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("idle_after_abort", 64'({busy, done, ovf, bcd}), 64'd0);
`endif

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
